// File: rtl/mem_pkg.sv
// Shared constants, encodings and helpers for the main memory unit.
package mem_pkg;

   localparam int unsigned MEM_DATA_WIDTH = 32;
   localparam int unsigned MEM_ADDR_WIDTH = 32;
   localparam int unsigned MEM_DEPTH      = 1048576;
   localparam logic [31:0] MEM_START_ADDR = 32'h8002_0000;
   localparam int unsigned BYTES_PER_WORD = 4;

   // Burst length encoding on access_size.
   typedef enum logic [1:0] {
      SZ_1  = 2'b00,
      SZ_4  = 2'b01,
      SZ_8  = 2'b10,
      SZ_16 = 2'b11
   } access_size_t;

   // Direction encoding on rw.
   typedef enum logic {
      RW_WRITE = 1'b0,
      RW_READ  = 1'b1
   } rw_t;

   // Burst controller states.
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } burst_state_t;

   // Number of beats in an access of the given size.
   function automatic logic [4:0] beat_count(input access_size_t sz);
      case (sz)
         SZ_1:    return 5'd1;
         SZ_4:    return 5'd4;
         SZ_8:    return 5'd8;
         default: return 5'd16;
      endcase
   endfunction

endpackage

// File: rtl/mem_burst_ctrl.sv
// IDLE/BURST sequencer: decides which beat executes on each edge, tracks the
// burst pointer and remaining count, and drives busy.
module mem_burst_ctrl
   import mem_pkg::*;
#(
   parameter int unsigned OFF_W = 20
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             enable,
   input  logic             rw,
   input  logic [1:0]       access_size,
   input  logic [OFF_W-1:0] offset,
   output logic             beat_c,
   output logic             beat_rw_c,
   output logic [OFF_W-1:0] beat_offset_c,
   output logic             busy
);

   burst_state_t     state;
   logic [OFF_W-1:0] ptr;
   logic [3:0]       count;
   logic             rw_q;

   // Select the beat for this edge: request inputs when idle, latched burst otherwise.
   always_comb begin
      beat_c        = 1'b0;
      beat_rw_c     = rw;
      beat_offset_c = offset;
      if (state == ST_BURST) begin
         beat_c        = reset_n;
         beat_rw_c     = rw_q;
         beat_offset_c = ptr;
      end else begin
         beat_c        = enable & reset_n;
      end
   end

   // Burst FSM with pointer, remaining-beat count and busy flag.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
         ptr   <= '0;
         count <= '0;
         rw_q  <= 1'b0;
         busy  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (enable && (access_size_t'(access_size) != SZ_1)) begin
                  ptr   <= offset + OFF_W'(BYTES_PER_WORD);
                  count <= 4'(beat_count(access_size_t'(access_size)) - 5'd1);
                  rw_q  <= rw;
                  state <= ST_BURST;
                  busy  <= 1'b1;
               end
            end
            ST_BURST: begin
               ptr   <= ptr + OFF_W'(BYTES_PER_WORD);
               count <= count - 4'd1;
               if (count == 4'd1) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/memory_unit.sv
// Byte-addressable big-endian main memory with single-word and burst access.
module memory_unit
   import mem_pkg::*;
#(
   parameter int unsigned                DATA_WIDTH    = MEM_DATA_WIDTH,
   parameter int unsigned                ADDRESS_WIDTH = MEM_ADDR_WIDTH,
   parameter int unsigned                DEPTH         = MEM_DEPTH,
   parameter logic [ADDRESS_WIDTH-1:0]   START_ADDR    = ADDRESS_WIDTH'(MEM_START_ADDR)
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic [ADDRESS_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0]    data_in,
   input  logic [1:0]               access_size,
   input  logic                     rw,
   input  logic                     enable,
   output logic                     busy,
   output logic [DATA_WIDTH-1:0]    data_out
);

   localparam int unsigned OFF_W = $clog2(DEPTH);

   logic [7:0]            mem [DEPTH];
   logic [OFF_W-1:0]      req_offset_c;
   logic                  beat_c;
   logic                  beat_rw_c;
   logic [OFF_W-1:0]      beat_offset_c;
   logic [DATA_WIDTH-1:0] rdata_c;

   // Storage offset of the requested address; wraps modulo DEPTH.
   assign req_offset_c = OFF_W'(address - START_ADDR);

   mem_burst_ctrl #(
      .OFF_W (OFF_W)
   ) u_ctrl (
      .clock         (clock),
      .reset_n       (reset_n),
      .enable        (enable),
      .rw            (rw),
      .access_size   (access_size),
      .offset        (req_offset_c),
      .beat_c        (beat_c),
      .beat_rw_c     (beat_rw_c),
      .beat_offset_c (beat_offset_c),
      .busy          (busy)
   );

   // Big-endian word gather; byte indices wrap past the top of storage.
   always_comb begin
      rdata_c = '0;
      for (int i = 0; i < int'(BYTES_PER_WORD); i++) begin
         logic [OFF_W-1:0] idx;
         idx = beat_offset_c + OFF_W'(i);
         rdata_c[DATA_WIDTH-1-8*i -: 8] = mem[idx];
      end
   end

   // Big-endian byte scatter on write beats; storage is never reset.
   always_ff @(posedge clock) begin
      if (beat_c && (beat_rw_c == RW_WRITE)) begin
         for (int i = 0; i < int'(BYTES_PER_WORD); i++) begin
            mem[beat_offset_c + OFF_W'(i)] <= data_in[DATA_WIDTH-1-8*i -: 8];
         end
      end
   end

   // Registered read data; only read beats update it.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         data_out <= '0;
      end else if (beat_c && (beat_rw_c == RW_READ)) begin
         data_out <= rdata_c;
      end
   end

endmodule

// File: tb/tb_memory_unit.sv
// Directed self-checking bench for memory_unit.
module tb_memory_unit;

   logic        clock;
   logic        reset_n;
   logic [31:0] address;
   logic [31:0] data_in;
   logic [1:0]  access_size;
   logic        rw;
   logic        enable;
   logic        busy;
   logic [31:0] data_out;

   int vectors;
   int miscompares;

   memory_unit dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .address     (address),
      .data_in     (data_in),
      .access_size (access_size),
      .rw          (rw),
      .enable      (enable),
      .busy        (busy),
      .data_out    (data_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Absolute time bound in case anything stalls.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running, need finished");
      $fatal(1, "timeout");
   end

   // Drive one edge's worth of inputs, step past the edge and settle.
   task automatic beat(input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz, input logic r, input logic en);
      address     = a;
      data_in     = d;
      access_size = sz;
      rw          = r;
      enable      = en;
      @(posedge clock);
      #1;
      enable      = 1'b0;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      address = '0; data_in = '0; access_size = 2'b00; rw = 1'b1; enable = 1'b0;
      #1;
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_busy: got %0b need 0", busy);
      end
      vectors++;
      if (data_out !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_data: got %08h need 00000000", data_out);
      end
      #7 reset_n = 1'b1;
      @(posedge clock);
      #1;
   endtask

   task automatic test_single;
      beat(32'h8002_0000, 32'h27BD_FFE8, 2'b00, 1'b0, 1'b1);
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL single_wr_busy: got %0b need 0", busy);
      end
      beat(32'h8002_0000, 32'h0, 2'b00, 1'b1, 1'b1);
      vectors++;
      if (data_out !== 32'h27BD_FFE8) begin
         miscompares++;
         $display("FAIL single_rd: got %08h need 27bdffe8", data_out);
      end
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL single_rd_busy: got %0b need 0", busy);
      end
   endtask

   task automatic test_unaligned;
      beat(32'h8002_0004, 32'h1122_3344, 2'b00, 1'b0, 1'b1);
      beat(32'h8002_0001, 32'h0, 2'b00, 1'b1, 1'b1);
      vectors++;
      if (data_out !== 32'hBDFF_E811) begin
         miscompares++;
         $display("FAIL unaligned_rd: got %08h need bdffe811", data_out);
      end
   endtask

   task automatic test_burst;
      logic [3:0] busy_need;
      logic [31:0] hold;
      busy_need = 4'b0111;
      hold = 32'hBDFF_E811;
      for (int i = 0; i < 4; i++) begin
         beat(32'h8002_0010, 32'hA0 + 32'(i), 2'b01, 1'b0, (i == 0));
         vectors++;
         if (busy !== busy_need[i]) begin
            miscompares++;
            $display("FAIL burst_wr_busy[%0d]: got %0b need %0b", i, busy, busy_need[i]);
         end
      end
      vectors++;
      if (data_out !== hold) begin
         miscompares++;
         $display("FAIL burst_wr_data_out_hold: got %08h need %08h", data_out, hold);
      end
      for (int i = 0; i < 4; i++) begin
         beat(32'h8002_0010, 32'h0, 2'b01, 1'b1, (i == 0));
         vectors++;
         if (data_out !== 32'hA0 + 32'(i)) begin
            miscompares++;
            $display("FAIL burst_rd[%0d]: got %08h need %08h", i, data_out, 32'hA0 + 32'(i));
         end
         vectors++;
         if (busy !== busy_need[i]) begin
            miscompares++;
            $display("FAIL burst_rd_busy[%0d]: got %0b need %0b", i, busy, busy_need[i]);
         end
      end
   endtask

   task automatic test_wrap;
      logic [31:0] addrs [5];
      logic [31:0] need  [5];
      beat(32'h800F_FFFE, 32'hDEAD_BEEF, 2'b00, 1'b0, 1'b1);
      beat(32'h8011_FFFE, 32'hDEAD_BEEF, 2'b00, 1'b0, 1'b1);
      addrs[0] = 32'h8002_0000; need[0] = 32'hBEEF_FFE8;
      addrs[1] = 32'h8011_FFFE; need[1] = 32'hDEAD_BEEF;
      addrs[2] = 32'h800F_FFFE; need[2] = 32'hDEAD_BEEF;
      addrs[3] = 32'h8011_FFFF; need[3] = 32'hADBE_EFFF;
      addrs[4] = 32'h8001_FFFE; need[4] = 32'hDEAD_BEEF;
      for (int i = 0; i < 5; i++) begin
         beat(addrs[i], 32'h0, 2'b00, 1'b1, 1'b1);
         vectors++;
         if (data_out !== need[i]) begin
            miscompares++;
            $display("FAIL wrap_rd[%0d] @%08h: got %08h need %08h", i, addrs[i], data_out, need[i]);
         end
      end
   endtask

   task automatic test_idle_enable;
      for (int i = 0; i < 4; i++) begin
         beat(32'h8002_0000 + 32'(4 * i), 32'h0, 2'(i), 1'(i), 1'b0);
         vectors++;
         if (data_out !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL idle_hold[%0d]: got %08h need deadbeef", i, data_out);
         end
      end
      beat(32'h8002_0000, 32'h0, 2'b00, 1'b1, 1'b1);
      vectors++;
      if (data_out !== 32'hBEEF_FFE8) begin
         miscompares++;
         $display("FAIL idle_storage: got %08h need beefffe8", data_out);
      end
   endtask

   task automatic test_reset_burst;
      for (int i = 0; i < 5; i++) begin
         beat(32'h8002_0040, 32'hB0 + 32'(i), 2'b11, 1'b0, (i == 0));
      end
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_burst_pre_busy: got %0b need 1", busy);
      end
      reset_n = 1'b0;
      #1;
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_burst_busy: got %0b need 0", busy);
      end
      vectors++;
      if (data_out !== 32'h0) begin
         miscompares++;
         $display("FAIL rst_burst_data: got %08h need 00000000", data_out);
      end
      #2 reset_n = 1'b1;
      beat(32'h8002_0040, 32'h0, 2'b00, 1'b1, 1'b1);
      vectors++;
      if (data_out !== 32'hB0) begin
         miscompares++;
         $display("FAIL rst_burst_kept0: got %08h need 000000b0", data_out);
      end
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_burst_single_busy: got %0b need 0", busy);
      end
      beat(32'h8002_0050, 32'h0, 2'b00, 1'b1, 1'b1);
      vectors++;
      if (data_out !== 32'hB4) begin
         miscompares++;
         $display("FAIL rst_burst_kept4: got %08h need 000000b4", data_out);
      end
      beat(32'h8002_0044, 32'h0, 2'b01, 1'b1, 1'b1);
      vectors++;
      if (data_out !== 32'hB1 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_burst_restart: got %08h/%0b need 000000b1/1", data_out, busy);
      end
      for (int i = 1; i < 4; i++) begin
         beat(32'h0, 32'h0, 2'b00, 1'b0, 1'b0);
      end
      vectors++;
      if (data_out !== 32'hB4 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_burst_restart_end: got %08h/%0b need 000000b4/0", data_out, busy);
      end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      test_reset();
      test_single();
      test_unaligned();
      test_burst();
      test_wrap();
      test_idle_enable();
      test_reset_burst();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/memory_unit.md
Name: memory_unit

Overview:
- Byte-addressable, big-endian, single-port synchronous main memory for the MIPS processor. It holds the program image and data.
- Mapped at base 0x80020000. The loader writes the image one word per clock; the fetch and load/store units read it back.
- Supports single-word and burst (4/8/16-word) accesses. busy is asserted while a burst is in progress.

Parameters:
- DATA_WIDTH, 32, data word width in bits; fixed at 32.
- ADDRESS_WIDTH, 32, address bus width in bits.
- DEPTH, 1048576, storage size in bytes; must be a power of two.
- START_ADDR, 32'h80020000, byte address that maps to storage byte 0.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  32  byte address of the first beat.
- data_in  in  32  write data, big-endian word.
- access_size  in  2  burst length: 00=1 word, 01=4 words, 10=8 words, 11=16 words.
- rw  in  1  0=write, 1=read.
- enable  in  1  starts an access when idle.
- busy  out  1  high while burst beats remain after the first.
- data_out  out  32  registered read data.

Behaviour:
- Address mapping:
  - offset = (address − START_ADDR) mod DEPTH, i.e. the low log2(DEPTH) bits of the difference.
  - Any address is accepted; there is no fault signal.
- Word layout is byte-granular and big-endian:
  - word at offset o = {mem[o], mem[o+1], mem[o+2], mem[o+3]}, each index mod DEPTH.
  - Unaligned accesses are legal. Accesses straddling the top of storage wrap to byte 0.
- Reset (reset_n=0, asynchronous):
  - State goes to IDLE; busy=0; data_out=0; the beat counter is cleared.
  - Storage contents are not cleared.
  - Reset during a burst aborts it immediately; bytes already written remain.
- State IDLE:
  - On a rising edge with enable=1, beat 0 executes at offset(address).
  - Write beat: the 4 bytes of data_in are stored.
  - Read beat: data_out takes the word at that offset on the same edge, so data is valid after the edge (1-cycle latency).
  - If access_size≠00: the next-beat pointer is set to offset+4, the remaining count to N−1 (3, 7 or 15), rw is latched, and the state moves to BURST with busy=1 from that edge.
  - enable=0: no access; data_out holds its value.
- State BURST:
  - Each rising edge executes one beat at the internal pointer. address, access_size, rw and enable are ignored.
  - Writes sample data_in on each edge.
  - The pointer advances by 4 (mod DEPTH) and the count decrements.
  - On the edge that executes the last beat (count=1→0), the state returns to IDLE and busy clears on that same edge.
  - A new access may start on the next edge.
- Reads do not alter storage. Writes do not alter data_out.
- A single-word access never raises busy. Back-to-back single-word accesses are allowed on every edge.

Decomposition:
- Shared package mem_pkg holds:
  - the START_ADDR, DEPTH and DATA_WIDTH constants;
  - an access_size enum (SZ_1, SZ_4, SZ_8, SZ_16) plus a function mapping it to beat count;
  - an rw encoding (RW_WRITE=0, RW_READ=1).
- One natural sub-module, mem_burst_ctrl: the IDLE/BURST FSM, beat counter, address pointer and busy.
- The top level holds the byte array, big-endian pack/unpack and the data_out register.

Test Plan:
- Reset: hold reset_n=0 mid-stream → busy=0, data_out=0 immediately, without waiting for a clock edge.
- Single write then read: write 0x27BDFFE8 at 0x80020000, then read the same address → data_out=0x27BDFFE8 one edge later, busy stays 0.
- Byte/unaligned read: after the previous write, read 0x80020001 with 0x11223344 stored at 0x80020004 → data_out=0xBDFFE811.
- Burst write/read: access_size=01 write at 0x80020010 with data 0xA0, 0xA1, 0xA2, 0xA3 on successive edges; busy high for 3 cycles. Then a 4-word burst read → data_out sequence 0xA0..0xA3 on consecutive edges, busy clears on the 4th edge.
- Wrap: write 0xDEADBEEF at 0x800FFFFE (offset 0xDFFFE) and at START_ADDR+DEPTH−2 → bytes DE AD land at offsets 0xFFFFE/0xFFFFF and BE EF at 0/1. A read at START_ADDR returns 0xBEEF in its top half.
- Idle/enable: enable=0 with changing address → data_out unchanged, storage unchanged. Reset asserted mid 16-word burst → busy=0 at once, next access starts normally.
